write_port_arbiter: RTL and testbench

- Shares the single SRAM write port among num_of_ports ingress ports, granting one port for a whole packet.
- Selects the next port round-robin, requests a base address from the free-space manager, streams beats to consecutive SRAM addresses, and reports a packet descriptor on completion.
- Sits between the ingress ports and the SRAM write side. It is the write-direction counterpart of read_arbiter.

---
 rtl/write_port_arbiter_if.sv | 43 ++++
 rtl/write_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_write_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/write_port_arbiter_if.sv
// Signal bundle between write_port_arbiter, its ingress ports, the free-space manager,
// the SRAM write side and the descriptor consumer.
interface write_port_arbiter_if #(
    parameter int num_of_ports       = 16,
    parameter int port_width         = 4,
    parameter int arbiter_data_width = 64,
    parameter int address_width      = 17,
    parameter int len_width          = 7
);
    logic [num_of_ports-1:0]                    req;
    logic [num_of_ports-1:0]                    wr_vld;
    logic [num_of_ports-1:0]                    wr_eop;
    logic [num_of_ports*arbiter_data_width-1:0] wr_data;
    logic [num_of_ports-1:0]                    grant;

    logic                                       addr_request;
    logic                                       addr_valid;
    logic [address_width-1:0]                   free_address;

    logic                                       wea;
    logic [address_width-1:0]                   addra;
    logic [arbiter_data_width-1:0]              dina;

    logic                                       pkt_done;
    logic [port_width-1:0]                      pkt_port;
    logic [address_width-1:0]                   pkt_head;
    logic [len_width-1:0]                       pkt_len;
    logic                                       pkt_trunc;

    // Environment side: ingress ports, address manager, SRAM and descriptor sink
    modport master (
        output req, wr_vld, wr_eop, wr_data, addr_valid, free_address,
        input  grant, addr_request, wea, addra, dina,
        input  pkt_done, pkt_port, pkt_head, pkt_len, pkt_trunc
    );

    // Arbiter side
    modport slave (
        input  req, wr_vld, wr_eop, wr_data, addr_valid, free_address,
        output grant, addr_request, wea, addra, dina,
        output pkt_done, pkt_port, pkt_head, pkt_len, pkt_trunc
    );
endinterface

// File: rtl/write_port_arbiter.sv
// Round-robin owner of the single SRAM write port: grants one ingress port per packet,
// streams its beats to consecutive addresses from a manager-supplied base, then reports a descriptor.
module write_port_arbiter #(
    parameter int num_of_ports       = 16,
    parameter int port_width         = 4,
    parameter int arbiter_data_width = 64,
    parameter int address_width      = 17,
    parameter int max_beats          = 64,
    parameter int len_width          = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    write_port_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        ALLOC,
        XFER,
        DRAIN,
        DONE
    } state_t;

    state_t                        state;
    logic [port_width-1:0]         rr_ptr;
    logic [port_width-1:0]         sel;
    logic [address_width-1:0]      base;
    logic [len_width-1:0]          beat_cnt;
    logic                          trunc;

    logic [port_width-1:0]         next_sel;
    logic [port_width-1:0]         scan_idx;
    logic                          scan_found;
    logic                          sel_vld;
    logic                          sel_eop;
    logic [arbiter_data_width-1:0] sel_data;
    logic                          last_stored_beat;

    // Scan rr_ptr+1, rr_ptr+2, ... wrapping, so the most recently served port comes last
    always_comb begin
        next_sel   = rr_ptr;
        scan_idx   = '0;
        scan_found = 1'b0;
        for (int k = 1; k <= num_of_ports; k++) begin
            scan_idx = rr_ptr + port_width'(k);
            if (!scan_found && bus.req[scan_idx]) begin
                next_sel   = scan_idx;
                scan_found = 1'b1;
            end
        end
    end

    assign sel_vld          = bus.wr_vld[sel];
    assign sel_eop          = bus.wr_eop[sel];
    assign sel_data         = bus.wr_data[sel*arbiter_data_width +: arbiter_data_width];
    assign last_stored_beat = (beat_cnt == len_width'(max_beats - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            rr_ptr           <= port_width'(num_of_ports - 1);
            sel              <= '0;
            base             <= '0;
            beat_cnt         <= '0;
            trunc            <= 1'b0;
            bus.grant        <= '0;
            bus.addr_request <= 1'b0;
            bus.wea          <= 1'b0;
            bus.addra        <= '0;
            bus.dina         <= '0;
            bus.pkt_done     <= 1'b0;
            bus.pkt_port     <= '0;
            bus.pkt_head     <= '0;
            bus.pkt_len      <= '0;
            bus.pkt_trunc    <= 1'b0;
        end else begin
            bus.wea      <= 1'b0;
            bus.pkt_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        sel              <= next_sel;
                        bus.addr_request <= 1'b1;
                        state            <= ALLOC;
                    end
                end

                ALLOC: begin
                    if (bus.addr_valid) begin
                        base             <= bus.free_address;
                        beat_cnt         <= '0;
                        bus.addr_request <= 1'b0;
                        bus.grant        <= {{(num_of_ports-1){1'b0}}, 1'b1} << sel;
                        state            <= XFER;
                    end
                end

                // addra wraps silently; keeping the region contiguous is the manager's job
                XFER: begin
                    if (sel_vld) begin
                        bus.wea   <= 1'b1;
                        bus.addra <= base + address_width'(beat_cnt);
                        bus.dina  <= sel_data;
                        beat_cnt  <= beat_cnt + 1'b1;
                        if (sel_eop) begin
                            bus.grant     <= '0;
                            bus.pkt_done  <= 1'b1;
                            bus.pkt_port  <= sel;
                            bus.pkt_head  <= base;
                            bus.pkt_len   <= beat_cnt + 1'b1;
                            bus.pkt_trunc <= trunc;
                            state         <= DONE;
                        end else if (last_stored_beat) begin
                            trunc <= 1'b1;
                            state <= DRAIN;
                        end
                    end
                end

                // Port keeps its grant so the oversized tail is consumed and discarded
                DRAIN: begin
                    if (sel_vld && sel_eop) begin
                        bus.grant     <= '0;
                        bus.pkt_done  <= 1'b1;
                        bus.pkt_port  <= sel;
                        bus.pkt_head  <= base;
                        bus.pkt_len   <= beat_cnt;
                        bus.pkt_trunc <= trunc;
                        state         <= DONE;
                    end
                end

                DONE: begin
                    rr_ptr <= sel;
                    trunc  <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_write_port_arbiter.sv
// Testbench for write_port_arbiter: a packet vector table plus hand-written reset/abort sequence,
// with write and descriptor scoreboards checked on the falling clock edge.
module tb_write_port_arbiter;

    localparam int NP   = 16;
    localparam int PW   = 4;
    localparam int DW   = 64;
    localparam int AW   = 17;
    localparam int MAXB = 64;
    localparam int LW   = 7;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_exp_t;

    typedef struct {
        int            port;
        logic [AW-1:0] head;
        int            len;
        bit            trunc;
    } desc_t;

    typedef struct {
        logic [NP-1:0] req_mask;
        logic [AW-1:0] base;
        int            beats;
        int            gap;
        int            delay;
        bit            idle_pulse;
        bit            hold;
        int            exp_port;
        int            exp_len;
        bit            exp_trunc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    wr_exp_t wq[$];
    desc_t   dq[$];
    wr_exp_t mon_w;
    desc_t   mon_d;
    vec_t    vecs[10];
    int      compared = 0;
    int      failed   = 0;
    int      cyc      = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    write_port_arbiter_if #(
        .num_of_ports(NP), .port_width(PW), .arbiter_data_width(DW),
        .address_width(AW), .len_width(LW)
    ) bus ();

    write_port_arbiter #(
        .num_of_ports(NP), .port_width(PW), .arbiter_data_width(DW),
        .address_width(AW), .max_beats(MAXB), .len_width(LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        bus.wr_vld       = '0;
        bus.wr_eop       = '0;
        bus.wr_data      = '0;
        bus.addr_valid   = 1'b0;
        bus.free_address = '0;
    endtask

    // Granted lane gets the real beat; every other lane and the address bus carry noise
    task automatic applyStimulus(input int port, input bit vld, input bit eop, input logic [DW-1:0] data);
        for (int i = 0; i < NP*DW/32; i++) bus.wr_data[i*32 +: 32] = $urandom;
        bus.wr_vld                 = NP'($urandom);
        bus.wr_eop                 = NP'($urandom);
        bus.wr_vld[port]           = vld;
        bus.wr_eop[port]           = eop;
        bus.wr_data[port*DW +: DW] = data;
        bus.addr_valid             = 1'($urandom);
        bus.free_address           = 17'h1DEAD;
    endtask

    task automatic waitAddrRequest(output bit ok);
        int guard;
        guard = 0;
        while (bus.addr_request !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        ok = (bus.addr_request === 1'b1);
        if (!ok) checkOutput("addr_request_timeout", 64'(bus.addr_request), 64'd1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_grant"},        64'(bus.grant),        64'd0);
        checkOutput({tag, "_addr_request"}, 64'(bus.addr_request), 64'd0);
        checkOutput({tag, "_wea"},          64'(bus.wea),          64'd0);
        checkOutput({tag, "_addra"},        64'(bus.addra),        64'd0);
        checkOutput({tag, "_dina"},         64'(bus.dina),         64'd0);
        checkOutput({tag, "_pkt_done"},     64'(bus.pkt_done),     64'd0);
        checkOutput({tag, "_pkt_port"},     64'(bus.pkt_port),     64'd0);
        checkOutput({tag, "_pkt_head"},     64'(bus.pkt_head),     64'd0);
        checkOutput({tag, "_pkt_len"},      64'(bus.pkt_len),      64'd0);
        checkOutput({tag, "_pkt_trunc"},    64'(bus.pkt_trunc),    64'd0);
    endtask

    task automatic runPacket(input vec_t v);
        bit            ok;
        logic [DW-1:0] data;
        logic [NP-1:0] exp_grant;
        exp_grant = NP'(1) << v.exp_port;

        if (v.idle_pulse) begin
            tick();
            bus.addr_valid   = 1'b1;
            bus.free_address = 17'h1ABCD;
            tick();
            clearInputs();
            tick();
            checkOutput("idle_pulse_addr_request", 64'(bus.addr_request), 64'd0);
            checkOutput("idle_pulse_grant",        64'(bus.grant),        64'd0);
        end

        bus.req = v.req_mask;
        waitAddrRequest(ok);
        if (!ok) return;
        if (!v.hold) bus.req = '0;
        checkOutput("grant_before_alloc", 64'(bus.grant), 64'd0);

        for (int d = 0; d < v.delay; d++) begin
            tick();
            checkOutput("addr_request_held", 64'(bus.addr_request), 64'd1);
            checkOutput("grant_while_alloc", 64'(bus.grant),        64'd0);
        end
        bus.addr_valid   = 1'b1;
        bus.free_address = v.base;
        tick();
        bus.addr_valid   = 1'b0;
        bus.free_address = 17'h1DEAD;
        checkOutput("grant",             64'(bus.grant),        64'(exp_grant));
        checkOutput("addr_request_drop", 64'(bus.addr_request), 64'd0);

        dq.push_back('{v.exp_port, v.base, v.exp_len, v.exp_trunc});
        for (int b = 0; b < v.beats; b++) begin
            if (b == 1) begin
                repeat (v.gap) begin
                    applyStimulus(v.exp_port, 1'b0, 1'($urandom), {$urandom, $urandom});
                    tick();
                end
            end
            data = {$urandom, $urandom};
            applyStimulus(v.exp_port, 1'b1, (b == v.beats - 1), data);
            if (b < MAXB) wq.push_back('{AW'(v.base + AW'(b)), data, cyc + 1});
            tick();
        end
        clearInputs();
        checkOutput("grant_after_eop", 64'(bus.grant), 64'd0);
    endtask

    // Scoreboard side: each write and descriptor is matched against the queued expectation
    always @(negedge clk) begin
        if (!rst && bus.wea) begin
            if (wq.size() == 0) begin
                compared++;
                failed++;
                $display("[TB] FAIL unexpected_write: addra=%0h dina=%0h, expected no write (cycle %0d)",
                         bus.addra, bus.dina, cyc);
            end else begin
                mon_w = wq.pop_front();
                checkOutput("addra",         64'(bus.addra), 64'(mon_w.addr));
                checkOutput("dina",          bus.dina,       mon_w.data);
                checkOutput("write_latency", 64'(cyc),       64'(mon_w.cyc));
            end
        end
        if (!rst && bus.pkt_done) begin
            if (dq.size() == 0) begin
                compared++;
                failed++;
                $display("[TB] FAIL unexpected_pkt_done: port=%0d head=%0h, expected none (cycle %0d)",
                         bus.pkt_port, bus.pkt_head, cyc);
            end else begin
                mon_d = dq.pop_front();
                checkOutput("pkt_port",  64'(bus.pkt_port),  64'(mon_d.port));
                checkOutput("pkt_head",  64'(bus.pkt_head),  64'(mon_d.head));
                checkOutput("pkt_len",   64'(bus.pkt_len),   64'(mon_d.len));
                checkOutput("pkt_trunc", 64'(bus.pkt_trunc), 64'(mon_d.trunc));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit            ok;
        logic [DW-1:0] data;
        vec_t          v;

        // req, base, beats, gap, delay, idle_pulse, hold, exp_port, exp_len, exp_trunc
        vecs[0] = '{16'h0001, 17'h00100,  4, 0,  1, 1'b0, 1'b0,  0,  4, 1'b0};
        vecs[1] = '{16'h8011, 17'h00200,  1, 0,  1, 1'b0, 1'b1,  4,  1, 1'b0};
        vecs[2] = '{16'h8011, 17'h00210,  1, 0,  1, 1'b0, 1'b1, 15,  1, 1'b0};
        vecs[3] = '{16'h8011, 17'h00220,  1, 0,  1, 1'b0, 1'b1,  0,  1, 1'b0};
        vecs[4] = '{16'h8011, 17'h00230,  1, 0,  1, 1'b0, 1'b1,  4,  1, 1'b0};
        vecs[5] = '{16'h8011, 17'h00240,  1, 0,  1, 1'b0, 1'b0, 15,  1, 1'b0};
        vecs[6] = '{16'h0008, 17'h00300,  2, 2,  1, 1'b0, 1'b0,  3,  2, 1'b0};
        vecs[7] = '{16'h0020, 17'h1FFF0, 70, 0,  1, 1'b0, 1'b0,  5, 64, 1'b1};
        vecs[8] = '{16'h0400, 17'h00800, 64, 0,  0, 1'b0, 1'b0, 10, 64, 1'b0};
        vecs[9] = '{16'h0001, 17'h00400,  3, 0, 10, 1'b1, 1'b0,  0,  3, 1'b0};

        rst     = 1'b1;
        bus.req = '0;
        clearInputs();
        repeat (3) tick();
        checkAllZero("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) runPacket(vecs[i]);

        // Abort mid-packet on port 2; the last served port was 0
        tick();
        tick();
        bus.req = 16'h0004;
        waitAddrRequest(ok);
        bus.req          = '0;
        bus.addr_valid   = 1'b1;
        bus.free_address = 17'h00500;
        tick();
        clearInputs();
        checkOutput("abort_grant", 64'(bus.grant), 64'h4);
        for (int b = 0; b < 2; b++) begin
            data = {$urandom, $urandom};
            applyStimulus(2, 1'b1, 1'b0, data);
            wq.push_back('{AW'(17'h00500 + AW'(b)), data, cyc + 1});
            tick();
        end
        @(negedge clk);
        #1;
        applyStimulus(2, 1'b1, 1'b0, {$urandom, $urandom});
        rst = 1'b1;
        #1;
        checkAllZero("abort");
        tick();
        clearInputs();
        tick();
        rst = 1'b0;
        tick();

        // Ports 0 and 5 request; a properly reset pointer favours port 0
        v = '{16'h0021, 17'h00600, 2, 0, 1, 1'b0, 1'b0, 0, 2, 1'b0};
        runPacket(v);

        repeat (4) tick();
        checkOutput("write_queue_empty", 64'(wq.size()), 64'd0);
        checkOutput("desc_queue_empty",  64'(dq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
